// File: rtl/e2_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package   : e2_mon_pkg
// Purpose   : Shared code constants, legal output masks and monitor FSM states
//             for the e2 output monitor.
// Revision  : 1.0 - initial release
// ============================================================================
package e2_mon_pkg;

  localparam logic [4:0] E2_DEST_NONE = 5'd0;
  localparam logic [4:0] E2_DEST_S2   = 5'd2;
  localparam logic [4:0] E2_DEST_S3   = 5'd3;
  localparam logic [4:0] E2_DEST_S4   = 5'd4;
  localparam logic [4:0] E2_DEST_S5   = 5'd5;
  localparam logic [4:0] E2_DEST_S7   = 5'd7;
  localparam logic [4:0] E2_DEST_S8   = 5'd8;
  localparam logic [4:0] E2_DEST_S9   = 5'd9;
  localparam logic [4:0] E2_DEST_S10  = 5'd10;
  localparam logic [4:0] E2_DEST_S11  = 5'd11;
  localparam logic [4:0] E2_DEST_S12  = 5'd12;
  localparam logic [4:0] E2_DEST_S13  = 5'd13;
  localparam logic [4:0] E2_DEST_S14  = 5'd14;
  localparam logic [4:0] E2_DEST_S15  = 5'd15;
  localparam logic [4:0] E2_DEST_S16  = 5'd16;
  localparam logic [4:0] E2_DEST_S17  = 5'd17;
  localparam logic [4:0] E2_DEST_S18  = 5'd18;

  // Bit n-1 of each mask is output yn.
  localparam logic [17:0] E2_MASK_S2  = 18'h00001;
  localparam logic [17:0] E2_MASK_S3  = 18'h00008;
  localparam logic [17:0] E2_MASK_S4  = 18'h20800;
  localparam logic [17:0] E2_MASK_S5  = 18'h00020;
  localparam logic [17:0] E2_MASK_S7  = 18'h04000;
  localparam logic [17:0] E2_MASK_S8  = 18'h01000;
  localparam logic [17:0] E2_MASK_S9  = 18'h00010;
  localparam logic [17:0] E2_MASK_S10 = 18'h00004;
  localparam logic [17:0] E2_MASK_S11 = 18'h00002;
  localparam logic [17:0] E2_MASK_S12 = 18'h08000;
  localparam logic [17:0] E2_MASK_S13 = 18'h00200;
  localparam logic [17:0] E2_MASK_S14 = 18'h00C01;
  localparam logic [17:0] E2_MASK_S15 = 18'h10080;
  localparam logic [17:0] E2_MASK_S16 = 18'h02000;
  localparam logic [17:0] E2_MASK_S17 = 18'h00D00;
  localparam logic [17:0] E2_MASK_S18 = 18'h000C0;

  typedef enum logic [1:0] {
    MON_OFF   = 2'd0,
    MON_TRACK = 2'd1,
    MON_ARMED = 2'd2
  } mon_state_t;

  // Exact-match decode; zero and every illegal vector both map to E2_DEST_NONE.
  function automatic logic [4:0] e2_decode(input logic [17:0] v);
    logic [4:0] r;
    case (v)
      E2_MASK_S2:  r = E2_DEST_S2;
      E2_MASK_S3:  r = E2_DEST_S3;
      E2_MASK_S4:  r = E2_DEST_S4;
      E2_MASK_S5:  r = E2_DEST_S5;
      E2_MASK_S7:  r = E2_DEST_S7;
      E2_MASK_S8:  r = E2_DEST_S8;
      E2_MASK_S9:  r = E2_DEST_S9;
      E2_MASK_S10: r = E2_DEST_S10;
      E2_MASK_S11: r = E2_DEST_S11;
      E2_MASK_S12: r = E2_DEST_S12;
      E2_MASK_S13: r = E2_DEST_S13;
      E2_MASK_S14: r = E2_DEST_S14;
      E2_MASK_S15: r = E2_DEST_S15;
      E2_MASK_S16: r = E2_DEST_S16;
      E2_MASK_S17: r = E2_DEST_S17;
      E2_MASK_S18: r = E2_DEST_S18;
      default:     r = E2_DEST_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/e2_mon_hist_fifo.sv
`default_nettype none
// ============================================================================
// Module    : e2_mon_hist_fifo
// Purpose   : Circular history buffer with valid/ready read port; a push into
//             a full buffer overwrites the oldest entry.
// Revision  : 1.0 - initial release
// ============================================================================
module e2_mon_hist_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int            C_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [C_AW:0] C_FULL = DEPTH[C_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr;
  logic [C_AW-1:0]  r_rd;
  logic [C_AW:0]    r_cnt;
  logic             w_full;
  logic             w_pop;

  assign w_full  = (r_cnt == C_FULL);
  assign o_valid = (r_cnt != '0);
  assign w_pop   = o_valid && i_ready;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr] <= i_data;
  end

  // Read pointer also advances on a full push so the oldest entry is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop || (i_push && w_full)) r_rd <= r_rd + 1'b1;
      if (i_push && !w_pop && !w_full) r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !i_push)       r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/e2_output_monitor.sv
`default_nettype none
// ============================================================================
// Module    : e2_output_monitor
// Purpose   : Passive decoder/checker of the e2 controller output vector.
//             Optional history FIFO enabled by macro E2MON_HIST_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module e2_output_monitor
  import e2_mon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int HIST_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [17:0]      y,
  output logic             dest_valid,
  output logic [4:0]       dest_code,
  output logic             illegal_err,
  output logic             alarm,
  output logic [CNT_W-1:0] move_cnt,
  output logic [CNT_W-1:0] alarm_cnt
`ifdef E2MON_HIST_EN
  ,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [4:0]       hist_code
`endif
);

  mon_state_t       r_state;
  logic             r_dest_valid;
  logic [4:0]       r_dest_code;
  logic             r_illegal_err;
  logic             r_alarm;
  logic [CNT_W-1:0] r_move_cnt;
  logic [CNT_W-1:0] r_alarm_cnt;

  logic [4:0]       w_code;
  logic             w_legal;
  logic             w_zero;

  assign w_code  = e2_decode(y);
  assign w_legal = (w_code != E2_DEST_NONE);
  assign w_zero  = (y == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= MON_OFF;
      r_dest_valid  <= 1'b0;
      r_dest_code   <= '0;
      r_illegal_err <= 1'b0;
      r_alarm       <= 1'b0;
      r_move_cnt    <= '0;
      r_alarm_cnt   <= '0;
    end else begin
      r_dest_valid <= 1'b0;
      r_dest_code  <= '0;
      if (clr) begin
        r_illegal_err <= 1'b0;
        r_alarm       <= 1'b0;
        r_move_cnt    <= '0;
        r_alarm_cnt   <= '0;
        if (r_state != MON_OFF) r_state <= MON_TRACK;
      end else if (en) begin
        // OFF is left on the first enabled edge, which is decoded as TRACK.
        if (w_legal) begin
          r_dest_valid <= 1'b1;
          r_dest_code  <= w_code;
          if (r_move_cnt != {CNT_W{1'b1}}) r_move_cnt <= r_move_cnt + 1'b1;
          r_state <= (w_code == E2_DEST_S18) ? MON_ARMED : MON_TRACK;
        end else if (!w_zero) begin
          r_illegal_err <= 1'b1;
          r_state       <= MON_TRACK;
        end else begin
          if (r_state == MON_ARMED) begin
            r_alarm <= 1'b1;
            if (r_alarm_cnt != {CNT_W{1'b1}}) r_alarm_cnt <= r_alarm_cnt + 1'b1;
          end
          r_state <= MON_TRACK;
        end
      end
    end
  end

  assign dest_valid  = r_dest_valid;
  assign dest_code   = r_dest_code;
  assign illegal_err = r_illegal_err;
  assign alarm       = r_alarm;
  assign move_cnt    = r_move_cnt;
  assign alarm_cnt   = r_alarm_cnt;

`ifdef E2MON_HIST_EN
  e2_mon_hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (5)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_push  (en && !clr && w_legal),
    .i_data  (w_code),
    .i_ready (hist_ready),
    .o_valid (hist_valid),
    .o_data  (hist_code)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_e2_output_monitor.sv
`default_nettype none
// ============================================================================
// Module    : tb_e2_output_monitor
// Purpose   : Randomized and directed self-checking bench for e2_output_monitor
//             against a table-driven behavioural model (E2MON_HIST_EN aware).
// Revision  : 1.0 - initial release
// ============================================================================
module tb_e2_output_monitor;

  localparam int CNT_W   = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en_i = 1'b0;
  logic             clr_i = 1'b0;
  logic [17:0]      y_i = '0;
  logic             rdy_i = 1'b0;
  logic             dest_valid;
  logic [4:0]       dest_code;
  logic             illegal_err;
  logic             alarm;
  logic [CNT_W-1:0] move_cnt;
  logic [CNT_W-1:0] alarm_cnt;
  logic             hist_valid;
  logic [4:0]       hist_code;

  e2_output_monitor #(.CNT_W(CNT_W), .HIST_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en_i),
    .clr         (clr_i),
    .y           (y_i),
    .dest_valid  (dest_valid),
    .dest_code   (dest_code),
    .illegal_err (illegal_err),
    .alarm       (alarm),
    .move_cnt    (move_cnt),
    .alarm_cnt   (alarm_cnt)
`ifdef E2MON_HIST_EN
    ,
    .hist_valid  (hist_valid),
    .hist_ready  (rdy_i),
    .hist_code   (hist_code)
`endif
  );

`ifndef E2MON_HIST_EN
  assign hist_valid = 1'b0;
  assign hist_code  = '0;
`endif

  always #5 clk = ~clk;

  // Legal code table written as the y-output numbers that must be high.
  int t_code [16] = '{2, 3, 4, 5, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};
  int t_ya   [16] = '{1, 4, 12, 6, 15, 13, 5, 3, 2, 16, 10, 1, 8, 14, 9, 7};
  int t_yb   [16] = '{0, 0, 18, 0, 0, 0, 0, 0, 0, 0, 0, 11, 17, 0, 11, 8};
  int t_yc   [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 12, 0};

  function automatic logic [17:0] ymask(input int k);
    logic [17:0] m;
    m = '0;
    if (t_ya[k] != 0) m[t_ya[k]-1] = 1'b1;
    if (t_yb[k] != 0) m[t_yb[k]-1] = 1'b1;
    if (t_yc[k] != 0) m[t_yc[k]-1] = 1'b1;
    return m;
  endfunction

  function automatic int lookup(input logic [17:0] v);
    for (int k = 0; k < 16; k++) if (v == ymask(k)) return t_code[k];
    return 0;
  endfunction

  function automatic logic [17:0] mask_of(input int code);
    for (int k = 0; k < 16; k++) if (t_code[k] == code) return ymask(k);
    return '0;
  endfunction

  // Behavioural model state
  int m_dv, m_dc, m_ill, m_alarm, m_mc, m_ac;
  bit m_armed;
  int m_q [$];

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_dv = 0; m_dc = 0; m_ill = 0; m_alarm = 0; m_mc = 0; m_ac = 0;
        m_armed = 1'b0;
        m_q.delete();
      end else begin
        int c;
        m_dv = 0;
        m_dc = 0;
        if (clr_i) begin
          m_ill = 0; m_alarm = 0; m_mc = 0; m_ac = 0;
          m_armed = 1'b0;
          m_q.delete();
        end else begin
          if (rdy_i && m_q.size() > 0) void'(m_q.pop_front());
          if (en_i) begin
            c = lookup(y_i);
            if (c != 0) begin
              m_dv = 1;
              m_dc = c;
              if (m_mc < CNT_MAX) m_mc++;
              m_armed = (c == 18);
`ifdef E2MON_HIST_EN
              m_q.push_back(c);
              if (m_q.size() > DEPTH) void'(m_q.pop_front());
`endif
            end else if (y_i != '0) begin
              m_ill = 1;
              m_armed = 1'b0;
            end else begin
              if (m_armed) begin
                m_alarm = 1;
                if (m_ac < CNT_MAX) m_ac++;
              end
              m_armed = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("dest_valid", int'(dest_valid), m_dv);
        chk("dest_code", int'(dest_code), m_dc);
        chk("illegal_err", int'(illegal_err), m_ill);
        chk("alarm", int'(alarm), m_alarm);
        chk("move_cnt", int'(move_cnt), m_mc);
        chk("alarm_cnt", int'(alarm_cnt), m_ac);
`ifdef E2MON_HIST_EN
        chk("hist_valid", int'(hist_valid), (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0) chk("hist_code", int'(hist_code), m_q[0]);
`endif
      end
    end
  end

  task automatic cyc(input logic e, input logic c, input logic [17:0] yy, input logic r);
    en_i = e; clr_i = c; y_i = yy; rdy_i = r;
    @(negedge clk);
  endtask

  initial begin : stim
    int lit_codes [10];
    logic [17:0] v;
    int sel;
    lit_codes = '{2, 3, 4, 5, 7, 8, 9, 10, 11, 12};
    @(negedge clk);
    @(negedge clk);
    chk("rst_dest_valid", int'(dest_valid), 0);
    chk("rst_move_cnt", int'(move_cnt), 0);
    chk("rst_hist_valid", int'(hist_valid), 0);
    rst = 1'b0;
    chk_on = 1'b1;

    cyc(1'b0, 1'b0, mask_of(4), 1'b0);
    chk("en0_no_valid", int'(dest_valid), 0);
    cyc(1'b1, 1'b0, mask_of(4), 1'b0);
    chk("first_valid", int'(dest_valid), 1);
    chk("first_code", int'(dest_code), 4);
    chk("first_cnt", int'(move_cnt), 1);
    cyc(1'b1, 1'b0, mask_of(18), 1'b0);
    chk("code18", int'(dest_code), 18);
    cyc(1'b1, 1'b0, mask_of(8), 1'b0);
    chk("code8", int'(dest_code), 8);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("no_alarm_after_8", int'(alarm), 0);
    cyc(1'b1, 1'b0, mask_of(18), 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("alarm_set", int'(alarm), 1);
    chk("alarm_cnt1", int'(alarm_cnt), 1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("alarm_cnt_hold", int'(alarm_cnt), 1);
    cyc(1'b1, 1'b0, 18'h00003, 1'b0);
    chk("illegal_set", int'(illegal_err), 1);
    chk("illegal_no_valid", int'(dest_valid), 0);
    chk("illegal_cnt_hold", int'(move_cnt), 4);
    cyc(1'b1, 1'b1, '0, 1'b0);
    chk("clr_illegal", int'(illegal_err), 0);
    chk("clr_alarm", int'(alarm), 0);

    // ARMED followed by an illegal vector: error only, and not left armed.
    cyc(1'b1, 1'b0, mask_of(18), 1'b0);
    cyc(1'b1, 1'b0, mask_of(18) | 18'h00001, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("armed_illegal_no_alarm", int'(alarm), 0);

    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, ymask(i % 15), 1'b0);
    chk("move_cnt_sat", int'(move_cnt), 15);
    cyc(1'b1, 1'b1, mask_of(5), 1'b0);
    chk("clr_wins_cnt", int'(move_cnt), 0);
    chk("clr_wins_valid", int'(dest_valid), 0);

`ifdef E2MON_HIST_EN
    foreach (lit_codes[i]) cyc(1'b1, 1'b0, mask_of(lit_codes[i]), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("hist_full_valid", int'(hist_valid), 1);
    for (int i = 2; i < 10; i++) begin
      chk("hist_drain", int'(hist_code), lit_codes[i]);
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    chk("hist_empty", int'(hist_valid), 0);
`else
    foreach (lit_codes[i]) cyc(1'b1, 1'b0, mask_of(lit_codes[i]), 1'b0);
    chk("last_code", int'(dest_code), 12);
`endif

    // Asynchronous reset while armed.
    cyc(1'b1, 1'b0, mask_of(18), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", int'(move_cnt), 0);
    chk("async_rst_code", int'(dest_code), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("no_armed_after_rst", int'(alarm), 0);

    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 3)      v = ymask(int'($urandom_range(0, 15)));
      else if (sel == 4) v = mask_of(18);
      else if (sel <= 6) v = '0;
      else if (sel == 7) v = ymask(int'($urandom_range(0, 15))) | (18'h00001 << $urandom_range(0, 17));
      else               v = 18'($urandom);
      en_i = ($urandom_range(0, 7) != 0);
      cyc(en_i, en_i && ($urandom_range(0, 49) == 0), v, 1'($urandom_range(0, 3) == 0));
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
